// File: rtl/rat_arb_pkg.sv
// Shared types, constants and the rotating-priority pick function for the
// four-requester mux arbiter.
package rat_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Select code that steers the shared mux to its all-zero default branch.
    localparam logic [3:0] SEL_NONE = 4'd4;

    // Reset value of the last-owner pointer: requester 0 is scanned first.
    localparam logic [1:0] LAST_RESET = 2'd3;

    // Winner = first requester found scanning last+1, last+2, ... (mod 4).
    // The previous owner is scanned last, giving it lowest priority.
    // Only meaningful when req is non-zero.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
        logic [1:0] idx;
        logic [1:0] win;
        logic       found;
        win   = last;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/mux_4t1_nb.sv
// n-bit 4-to-1 datapath mux. Any select code other than 0..3 drives zero,
// which the arbiter uses to blank the output while idle.
module mux_4t1_nb #(
    parameter int n = 8
) (
    input  logic [3:0]   SEL,
    input  logic [n-1:0] D0,
    input  logic [n-1:0] D1,
    input  logic [n-1:0] D2,
    input  logic [n-1:0] D3,
    output logic [n-1:0] D_OUT
);

    // Pure combinational selection; the default branch covers "no owner".
    always_comb begin
        D_OUT = '0;
        case (SEL)
            4'd0:    D_OUT = D0;
            4'd1:    D_OUT = D1;
            4'd2:    D_OUT = D2;
            4'd3:    D_OUT = D3;
            default: D_OUT = '0;
        endcase
    end

endmodule

// File: rtl/rr_arb_4t1.sv
// Round-robin arbiter sharing one n-bit 4-to-1 mux among four requesters.
// Grant and select are registered; every release or forced rotation passes
// through exactly one idle cycle before the next grant.
module rr_arb_4t1
    import rat_arb_pkg::*;
#(
    parameter int n        = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [3:0]   REQ,
    input  logic [n-1:0] D0,
    input  logic [n-1:0] D1,
    input  logic [n-1:0] D2,
    input  logic [n-1:0] D3,
    output logic [3:0]   GNT,
    output logic [3:0]   SEL,
    output logic [n-1:0] D_OUT,
    output logic         BUSY
);

    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

    arb_state_t state_reg, state_next;
    logic [3:0] gnt_reg,   gnt_next;
    logic [3:0] sel_reg,   sel_next;
    logic [1:0] last_reg,  last_next;
    logic [7:0] cnt_reg,   cnt_next;

    logic [3:0] competitors;
    logic       owner_req;
    logic       hold_done;
    logic [1:0] winner;

    // Requests from anyone other than the current owner (gnt_reg is zero
    // while idle, so this is simply REQ then).
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_comp
            assign competitors[gi] = REQ[gi] & ~gnt_reg[gi];
        end
    endgenerate

    assign owner_req = |(REQ & gnt_reg);
    assign hold_done = (cnt_reg == HOLD_LIMIT);
    assign winner    = rr_pick(REQ, last_reg);

    // State register; reset overrides every other event on the edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= IDLE;
            gnt_reg   <= 4'b0000;
            sel_reg   <= SEL_NONE;
            last_reg  <= LAST_RESET;
            cnt_reg   <= 8'd0;
        end else begin
            state_reg <= state_next;
            gnt_reg   <= gnt_next;
            sel_reg   <= sel_next;
            last_reg  <= last_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state logic: pick a winner from idle, or decide hold/release/preempt.
    always_comb begin
        state_next = state_reg;
        gnt_next   = gnt_reg;
        sel_next   = sel_reg;
        last_next  = last_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (REQ != 4'b0000) begin
                    state_next = GRANT;
                    gnt_next   = onehot4(winner);
                    sel_next   = {2'b00, winner};
                    last_next  = winner;
                    cnt_next   = 8'd1;
                end
            end
            GRANT: begin
                if (!owner_req || (hold_done && (competitors != 4'b0000))) begin
                    state_next = IDLE;
                    gnt_next   = 4'b0000;
                    sel_next   = SEL_NONE;
                    cnt_next   = 8'd0;
                end else if (!hold_done) begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            default: begin
                state_next = IDLE;
                gnt_next   = 4'b0000;
                sel_next   = SEL_NONE;
                cnt_next   = 8'd0;
            end
        endcase
    end

    assign GNT  = gnt_reg;
    assign SEL  = sel_reg;
    assign BUSY = (state_reg == GRANT);

    mux_4t1_nb #(.n(n)) u_mux (
        .SEL   (sel_reg),
        .D0    (D0),
        .D1    (D1),
        .D2    (D2),
        .D3    (D3),
        .D_OUT (D_OUT)
    );

endmodule

// File: tb/tb_rr_arb_4t1.sv
// Bench for rr_arb_4t1: directed scenarios with literal expectations plus a
// randomized phase, all outputs checked each cycle against an owner/queue
// level model of the arbitration rules.
module tb_rr_arb_4t1;

    localparam int N  = 8;
    localparam int MH = 4;

    logic         clk;
    logic         RST;
    logic [3:0]   REQ;
    logic [N-1:0] d_val [4];
    logic [3:0]   GNT;
    logic [3:0]   SEL;
    logic [N-1:0] D_OUT;
    logic         BUSY;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: owner index (-1 = nobody), rotation pointer, hold age.
    int m_owner = -1;
    int m_last  = 3;
    int m_hold  = 0;

    rr_arb_4t1 #(.n(N), .MAX_HOLD(MH)) dut (
        .CLK   (clk),
        .RST   (RST),
        .REQ   (REQ),
        .D0    (d_val[0]),
        .D1    (d_val[1]),
        .D2    (d_val[2]),
        .D3    (d_val[3]),
        .GNT   (GNT),
        .SEL   (SEL),
        .D_OUT (D_OUT),
        .BUSY  (BUSY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Advance the model by one clock using the inputs seen at the edge.
    task automatic model_update();
        int others;
        if (RST) begin
            m_owner = -1;
            m_last  = 3;
            m_hold  = 0;
        end else if (m_owner < 0) begin
            for (int k = 1; k <= 4; k++) begin
                int i;
                i = (m_last + k) % 4;
                if (m_owner < 0 && REQ[i]) begin
                    m_owner = i;
                    m_last  = i;
                    m_hold  = 1;
                end
            end
        end else begin
            others = int'(REQ) & ~(1 << m_owner);
            if (!REQ[m_owner] || (m_hold == MH && others != 0)) begin
                m_owner = -1;
                m_hold  = 0;
            end else if (m_hold < MH) begin
                m_hold++;
            end
        end
    endtask

    task automatic model_check();
        int e_gnt, e_sel, e_dout, e_busy;
        e_gnt  = (m_owner < 0) ? 0 : (1 << m_owner);
        e_sel  = (m_owner < 0) ? 4 : m_owner;
        e_busy = (m_owner < 0) ? 0 : 1;
        e_dout = (m_owner < 0) ? 0 : int'(d_val[m_owner]);
        chk("model_gnt",  int'(GNT),   e_gnt);
        chk("model_sel",  int'(SEL),   e_sel);
        chk("model_busy", int'(BUSY),  e_busy);
        chk("model_dout", int'(D_OUT), e_dout);
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        model_check();
    endtask

    task automatic do_reset();
        RST = 1'b1;
        step();
        RST = 1'b0;
    endtask

    int exp3 [24] = '{1,1,1,1,0, 2,2,2,2,0, 4,4,4,4,0, 8,8,8,8,0, 1,1,1,1};
    logic [3:0] flip;

    initial begin
        RST = 1'b1;
        REQ = 4'b1111;
        for (int i = 0; i < 4; i++) d_val[i] = N'(8'h10 + i);

        // Reset held two cycles with all requests asserted.
        for (int c = 0; c < 2; c++) begin
            step();
            chk("reset_gnt",  int'(GNT),   0);
            chk("reset_sel",  int'(SEL),   4);
            chk("reset_dout", int'(D_OUT), 0);
            chk("reset_busy", int'(BUSY),  0);
        end
        RST = 1'b0;
        REQ = 4'b0000;
        step();

        // Single requester 2 with data A5.
        REQ = 4'b0100;
        d_val[2] = 8'hA5;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("single_gnt",  int'(GNT),   4'b0100);
            chk("single_sel",  int'(SEL),   2);
            chk("single_dout", int'(D_OUT), 8'hA5);
        end
        d_val[2] = 8'h5A;
        #1;
        chk("single_dout_live", int'(D_OUT), 8'h5A);
        REQ = 4'b0000;
        step();
        chk("release_gnt",  int'(GNT),   0);
        chk("release_dout", int'(D_OUT), 0);

        // Full contention from reset: order 0,1,2,3,0, four cycles each.
        REQ = 4'b1111;
        do_reset();
        for (int c = 0; c < 24; c++) begin
            step();
            chk("contention_gnt", int'(GNT), exp3[c]);
        end

        // Lone requester is never preempted.
        REQ = 4'b0010;
        do_reset();
        for (int c = 0; c < 20; c++) begin
            step();
            chk("hold_gnt", int'(GNT), 4'b0010);
        end

        // Handover on release: owner 3 drops with 0 pending.
        REQ = 4'b1000;
        do_reset();
        step();
        chk("hand_own3", int'(GNT), 4'b1000);
        REQ = 4'b1001;
        step();
        chk("hand_keep3", int'(GNT), 4'b1000);
        REQ = 4'b0001;
        d_val[0] = 8'h3C;
        step();
        chk("hand_idle", int'(GNT), 0);
        step();
        chk("hand_gnt0",  int'(GNT),   4'b0001);
        chk("hand_dout0", int'(D_OUT), 8'h3C);

        // Reset mid-grant restores the rotation pointer.
        REQ = 4'b0100;
        do_reset();
        step();
        step();
        chk("midrst_own2", int'(GNT), 4'b0100);
        REQ = 4'b0011;
        RST = 1'b1;
        step();
        chk("midrst_gnt", int'(GNT), 0);
        RST = 1'b0;
        step();
        chk("midrst_gnt0", int'(GNT), 4'b0001);

        // Randomized traffic with sticky requests and rare resets.
        for (int c = 0; c < 3000; c++) begin
            flip = 4'($urandom) & 4'($urandom);
            REQ  = REQ ^ flip;
            RST  = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < 4; i++) d_val[i] = N'($urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
